display_source_sched: RTL and testbench
=======================================

// Module: display_source_sched
// PURPOSE
//  Time-shares the 8-digit 7-segment display among N_SRC 32-bit status sources (hash cores, counters).
//  Rotates round-robin over valid sources with a fixed dwell time, or pins one source on request.
//  Drives the 32-bit number input of the multiplexed display driver and the source-indicator LEDs.
// PARAMETERS
//  N_SRC    4            number of sources, 2..8
//  DWELL    100000000    cycles each source stays on screen (1 s at 100 MHz), >= 2
//  IW       $clog2(N_SRC)   index width (derived, localparam)
// PORTS
//  CLK         in   1          system clock, all logic on rising edge
//  RESET_N     in   1          synchronous reset, active low
//  src_data    in   32*N_SRC   source i occupies bits [32*i+31:32*i]
//  src_valid   in   N_SRC      source i has data worth displaying
//  pin_req     in   1          level: freeze display on pin_sel
//  pin_sel     in   IW         source to pin
//  number_out  out  32         value to the display driver
//  src_idx     out  IW         index currently shown
//  src_onehot  out  N_SRC      one-hot of src_idx, all zero in IDLE
//  switch_stb  out  1          1-cycle pulse when the shown source changes
// BEHAVIOUR
//  Reset (RESET_N low at a CLK edge, any state): state=IDLE, number_out=0, src_idx=0, src_onehot=0,
//   switch_stb=0, dwell counter=0. Reset mid-rotation or mid-pin discards everything; no memory kept.
//  States: IDLE, ROTATE, PINNED. Priority per cycle: reset > pin > rotate > idle.
//  IDLE: number_out=0. If pin_req -> PINNED on pin_sel. Else if any src_valid -> ROTATE on the
//   lowest-index valid source. Entry to either state: counter=0, switch_stb=1.
//  ROTATE: counter increments each cycle. At counter==DWELL-1, or if src_valid[src_idx] is low,
//   next cycle selects the next valid index above src_idx, wrapping modulo N_SRC (search excludes
//   current index unless it is the only valid one); counter=0. switch_stb pulses only if index changes.
//   No valid source at all -> IDLE next cycle (number_out returns to 0).
//   pin_req high -> PINNED next cycle.
//  PINNED: src_idx=pin_sel (re-sampled every cycle; change of pin_sel pulses switch_stb), shown
//   regardless of src_valid; counter held at 0. pin_req low -> ROTATE starting at the next valid
//   index above the pinned one (IDLE if none valid), counter=0.
//  pin_sel >= N_SRC: treated as index N_SRC-1.
//  Data path: number_out <= src_data[src_idx] every cycle while not IDLE (live tracking, 1-cycle
//   registered latency from src_data and from the src_idx update). src_onehot registered with src_idx.
//  switch_stb asserted in the same cycle src_idx first shows its new value; never two in a row
//   unless the index actually changes twice.
//  Counter width $clog2(DWELL); no wrap beyond DWELL-1.
// TESTING
//  Bench uses N_SRC=4, DWELL=8.
//  1 Reset: hold RESET_N=0 5 cycles with src_valid=4'hF -> all outputs 0, state IDLE; release ->
//    src_idx=0 next cycle, switch_stb=1, number_out=src_data[0] one cycle later.
//  2 Rotation: src_valid=4'b1011, data 0xA0..0xA3 -> shown order 0,1,3,0 each exactly 8 cycles,
//    one switch_stb per change, index 2 never shown.
//  3 Drop-out: while showing 1 at count 3 deassert src_valid[1] -> index 3 shown next cycle,
//    counter restarts; all valid low -> IDLE, number_out=0 within 2 cycles.
//  4 Pin: pin_req=1, pin_sel=2 with src_valid[2]=0 -> src_idx=2 held 50 cycles, number_out tracks
//    src_data[2] changes with 1-cycle latency; release -> index 3 (next valid above 2).
//  5 Single source: src_valid=4'b0100 -> src_idx stays 2, no switch_stb after the first.
//  6 Reset mid-pin: RESET_N=0 for 1 cycle during PINNED -> IDLE outputs, then rotate from lowest valid.

Source files
------------

// File: rtl/display_source_sched.sv
// display_source_sched: shares the 8-digit display among N_SRC 32-bit status
// sources. It steps round-robin through the valid sources with a fixed dwell,
// or holds one source while a pin is requested.
module display_source_sched #(
   parameter int unsigned N_SRC = 4,
   parameter int unsigned DWELL = 100000000
) (
   input  logic                         CLK,
   input  logic                         RESET_N,
   input  logic [32*N_SRC-1:0]          src_data,
   input  logic [N_SRC-1:0]             src_valid,
   input  logic                         pin_req,
   input  logic [$clog2(N_SRC)-1:0]     pin_sel,
   output logic [31:0]                  number_out,
   output logic [$clog2(N_SRC)-1:0]     src_idx,
   output logic [N_SRC-1:0]             src_onehot,
   output logic                         switch_stb
);

   localparam int unsigned IW = $clog2(N_SRC);
   localparam int unsigned CW = $clog2(DWELL);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROTATE = 2'd1,
      PINNED = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   idx_d;
   logic            stb_d;

   logic [31:0]     src_word [N_SRC];
   logic            any_valid;
   logic [IW-1:0]   low_idx;
   logic [IW-1:0]   nxt_idx;
   logic [IW-1:0]   pin_idx;

   for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
      assign src_word[g] = src_data[32*g +: 32];
   end

   assign any_valid = |src_valid;

   // Out-of-range pin requests show the highest source.
   always_comb begin
      pin_idx = pin_sel;
      if (int'(pin_sel) >= int'(N_SRC)) pin_idx = IW'(N_SRC - 1);
   end

   // Lowest-index valid source, used when leaving IDLE.
   always_comb begin
      low_idx = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (src_valid[IW'(N_SRC - 1 - i)]) low_idx = IW'(N_SRC - 1 - i);
      end
   end

   // Next valid source above src_idx with wrap. Offsets are scanned from
   // largest to smallest so the nearest hit wins; offset N_SRC maps back to
   // src_idx itself, which is therefore chosen only when nothing else is valid.
   always_comb begin
      int unsigned cand;
      nxt_idx = src_idx;
      cand    = 0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         cand = (int'(src_idx) + N_SRC - i) % N_SRC;
         if (src_valid[IW'(cand)]) nxt_idx = IW'(cand);
      end
   end

   // Next-state, next-index, counter and strobe decisions.
   always_comb begin
      state_d = state_q;
      idx_d   = src_idx;
      cnt_d   = cnt_q;
      stb_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pin_req) begin
               state_d = PINNED;
               idx_d   = pin_idx;
               cnt_d   = '0;
               stb_d   = 1'b1;
            end else if (any_valid) begin
               state_d = ROTATE;
               idx_d   = low_idx;
               cnt_d   = '0;
               stb_d   = 1'b1;
            end
         end
         ROTATE: begin
            if (pin_req) begin
               state_d = PINNED;
               idx_d   = pin_idx;
               cnt_d   = '0;
               stb_d   = (pin_idx != src_idx);
            end else if (!any_valid) begin
               state_d = IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q == CW'(DWELL - 1) || !src_valid[src_idx]) begin
               idx_d = nxt_idx;
               cnt_d = '0;
               stb_d = (nxt_idx != src_idx);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PINNED: begin
            cnt_d = '0;
            if (pin_req) begin
               idx_d = pin_idx;
               stb_d = (pin_idx != src_idx);
            end else if (!any_valid) begin
               state_d = IDLE;
               idx_d   = '0;
            end else begin
               state_d = ROTATE;
               idx_d   = nxt_idx;
               stb_d   = (nxt_idx != src_idx);
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // State, index, counter and registered outputs; number_out follows the
   // index already on screen, giving one cycle of latency after a switch.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         src_idx    <= '0;
         src_onehot <= '0;
         switch_stb <= 1'b0;
         number_out <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         src_idx    <= idx_d;
         src_onehot <= (state_d == IDLE) ? '0 : (N_SRC'(1) << idx_d);
         switch_stb <= stb_d;
         number_out <= (state_q == IDLE) ? '0 : src_word[src_idx];
      end
   end

endmodule

// File: tb/tb_display_source_sched.sv
// Directed bench for display_source_sched with N_SRC=4, DWELL=8.
module tb_display_source_sched;

   logic          CLK = 1'b0;
   logic          RESET_N;
   logic [127:0]  src_data;
   logic [3:0]    src_valid;
   logic          pin_req;
   logic [1:0]    pin_sel;
   logic [31:0]   number_out;
   logic [1:0]    src_idx;
   logic [3:0]    src_onehot;
   logic          switch_stb;

   logic [31:0]   data [4];
   int            checks = 0;
   int            errors = 0;

   display_source_sched #(.N_SRC(4), .DWELL(8)) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .src_data   (src_data),
      .src_valid  (src_valid),
      .pin_req    (pin_req),
      .pin_sel    (pin_sel),
      .number_out (number_out),
      .src_idx    (src_idx),
      .src_onehot (src_onehot),
      .switch_stb (switch_stb)
   );

   always #5 CLK = ~CLK;

   // Pack the per-source words onto the flat bus.
   always_comb src_data = {data[3], data[2], data[1], data[0]};

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int      order [4];
      int      prev;
      int      cur;
      order = '{0, 1, 3, 0};

      RESET_N   = 1'b0;
      pin_req   = 1'b0;
      pin_sel   = 2'd0;
      src_valid = 4'hF;
      data[0] = 32'hA0; data[1] = 32'hA1; data[2] = 32'hA2; data[3] = 32'hA3;

      // 1: reset held 5 cycles, then release.
      repeat (5) tick();
      chk("rst_num",    number_out, 32'h0);
      chk("rst_idx",    32'(src_idx), 32'd0);
      chk("rst_onehot", 32'(src_onehot), 32'h0);
      chk("rst_stb",    32'(switch_stb), 32'd0);
      RESET_N = 1'b1;
      tick();
      chk("rel_idx",    32'(src_idx), 32'd0);
      chk("rel_stb",    32'(switch_stb), 32'd1);
      chk("rel_onehot", 32'(src_onehot), 32'h1);
      chk("rel_num0",   number_out, 32'h0);
      tick();
      chk("rel_num1",   number_out, 32'hA0);
      chk("rel_stb1",   32'(switch_stb), 32'd0);

      // 2: rotation over 1011 -> 0,1,3,0 for 8 cycles each.
      RESET_N   = 1'b0;
      src_valid = 4'b1011;
      tick();
      RESET_N = 1'b1;
      prev = -1;
      for (int k = 0; k < 32; k++) begin
         tick();
         cur = order[k / 8];
         chk("rot_idx", 32'(src_idx), 32'(cur));
         chk("rot_oh",  32'(src_onehot), 32'(1) << cur);
         chk("rot_stb", 32'(switch_stb), (k % 8 == 0) ? 32'd1 : 32'd0);
         chk("rot_num", number_out, (prev < 0) ? 32'h0 : 32'hA0 + 32'(prev));
         prev = cur;
      end

      // 3: drop-out of source 1 at count 3, then all sources gone.
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("drop_pre", 32'(src_idx), 32'd1);
      end
      src_valid = 4'b1001;
      tick();
      chk("drop_idx", 32'(src_idx), 32'd3);
      chk("drop_stb", 32'(switch_stb), 32'd1);
      for (int k = 0; k < 7; k++) begin
         tick();
         chk("drop_hold", 32'(src_idx), 32'd3);
         chk("drop_hstb", 32'(switch_stb), 32'd0);
      end
      tick();
      chk("drop_wrap", 32'(src_idx), 32'd0);
      chk("drop_wstb", 32'(switch_stb), 32'd1);
      src_valid = 4'b0000;
      tick();
      chk("idle_oh1",  32'(src_onehot), 32'h0);
      tick();
      chk("idle_num",  number_out, 32'h0);
      chk("idle_oh2",  32'(src_onehot), 32'h0);
      chk("idle_stb",  32'(switch_stb), 32'd0);

      // 4: pin on an invalid source, live data tracking, pin_sel change, release.
      src_valid = 4'b1001;
      pin_req   = 1'b1;
      pin_sel   = 2'd2;
      tick();
      chk("pin_idx",  32'(src_idx), 32'd2);
      chk("pin_stb",  32'(switch_stb), 32'd1);
      chk("pin_oh",   32'(src_onehot), 32'h4);
      tick();
      chk("pin_num",  number_out, 32'hA2);
      for (int k = 0; k < 50; k++) begin
         data[2] = 32'hB000_0000 + 32'(k);
         tick();
         chk("pin_hold", 32'(src_idx), 32'd2);
         chk("pin_hstb", 32'(switch_stb), 32'd0);
         chk("pin_trk",  number_out, 32'hB000_0000 + 32'(k));
      end
      pin_sel = 2'd0;
      tick();
      chk("pin_sel0", 32'(src_idx), 32'd0);
      chk("pin_sstb", 32'(switch_stb), 32'd1);
      pin_sel = 2'd2;
      tick();
      chk("pin_sel2", 32'(src_idx), 32'd2);
      chk("pin_s2stb", 32'(switch_stb), 32'd1);
      pin_req = 1'b0;
      tick();
      chk("unpin_idx", 32'(src_idx), 32'd3);
      chk("unpin_stb", 32'(switch_stb), 32'd1);
      tick();
      chk("unpin_num", number_out, 32'hA3);

      // 5: single valid source stays on screen with no further strobes.
      RESET_N   = 1'b0;
      src_valid = 4'b0100;
      data[2]   = 32'hA2;
      tick();
      RESET_N = 1'b1;
      tick();
      chk("one_idx", 32'(src_idx), 32'd2);
      chk("one_stb", 32'(switch_stb), 32'd1);
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("one_hold", 32'(src_idx), 32'd2);
         chk("one_hstb", 32'(switch_stb), 32'd0);
      end

      // 6: reset during PINNED, then rotate from lowest valid.
      pin_req = 1'b1;
      pin_sel = 2'd1;
      tick();
      chk("rp_pin",  32'(src_idx), 32'd1);
      chk("rp_stb",  32'(switch_stb), 32'd1);
      tick();
      src_valid = 4'b1010;
      RESET_N   = 1'b0;
      pin_req   = 1'b0;
      tick();
      chk("rp_num",  number_out, 32'h0);
      chk("rp_idx",  32'(src_idx), 32'd0);
      chk("rp_oh",   32'(src_onehot), 32'h0);
      chk("rp_zstb", 32'(switch_stb), 32'd0);
      RESET_N = 1'b1;
      tick();
      chk("rp_rot",  32'(src_idx), 32'd1);
      chk("rp_rstb", 32'(switch_stb), 32'd1);
      chk("rp_roh",  32'(src_onehot), 32'h2);
      tick();
      chk("rp_rnum", number_out, 32'hA1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
